// File: rtl/kuznechik_encoder_pkg.sv
// kuznechik_pkg: shared constants, FSM encoding and GF(2^8) multiply for the Kuznechik cipher core.
package kuznechik_pkg;
    localparam logic [7:0] GF_POLY = 8'hC3;
    localparam int ROUNDS = 9;
    localparam int RSTEPS = 16;
    // index i is the coefficient applied to byte a_i
    localparam logic [15:0][7:0] L_COEF = {8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                                           8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};
    typedef enum logic [1:0] {IDLE, SX, LIN, FIN} state_t;
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = x[7] ? {x[6:0], 1'b0} ^ GF_POLY : {x[6:0], 1'b0};
        end
        return p;
    endfunction
endpackage

// File: rtl/kuznechik_encoder_if.sv
// kuznechik_encoder_if: start/data/key request and ciphertext response bundle of the encryptor.
interface kuznechik_encoder_if;
    logic          start_i;
    logic [127:0]  data_i;
    logic [1279:0] round_keys_i;
    logic [127:0]  data_o;
    logic          done_o;
    logic          busy_o;
    modport master (output start_i, data_i, round_keys_i, input data_o, done_o, busy_o);
    modport slave  (input start_i, data_i, round_keys_i, output data_o, done_o, busy_o);
endinterface

// File: rtl/s_convertion.sv
// s_convertion: combinational forward pi substitution of one byte.
module s_convertion (
    input  logic [7:0] x,
    output logic [7:0] y
);
    localparam logic [7:0] PI [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };
    assign y = PI[x];
endmodule

// File: rtl/kuznechik_encoder.sv
// kuznechik_encoder: iterative Kuznechik encryptor; one X+S step or one R step per cycle, 154-cycle latency.
module kuznechik_encoder
    import kuznechik_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    kuznechik_encoder_if.slave bus
);
    state_t state, next_state;
    logic [127:0] state_reg, state_d, sx_in, s_out, r_out;
    logic [3:0] round, round_d, rstep, rstep_d;
    logic [9:0][127:0] keys;
    logic [7:0] l_val;
    // keys[9] is K1, keys[0] is K10
    assign keys  = bus.round_keys_i;
    assign sx_in = state_reg ^ keys[4'd9 - round];
    assign r_out = {l_val, state_reg[127:8]};
    for (genvar g = 0; g < 16; g++) begin : g_sbox
        s_convertion u_s (.x(sx_in[8*g +: 8]), .y(s_out[8*g +: 8]));
    end
    always_comb begin
        l_val = '0;
        for (int i = 0; i < 16; i++) l_val ^= gf_mul(state_reg[8*i +: 8], L_COEF[i]);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = bus.start_i ? SX : IDLE;
            SX:      next_state = LIN;
            LIN:     next_state = rstep != 4'(RSTEPS - 1) ? LIN : round == 4'(ROUNDS - 1) ? FIN : SX;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        state_d = state_reg;
        round_d = round;
        rstep_d = rstep;
        case (state)
            IDLE: begin
                state_d = bus.start_i ? bus.data_i : state_reg;
                round_d = bus.start_i ? 4'd0 : round;
            end
            SX: begin
                state_d = s_out;
                rstep_d = 4'd0;
            end
            LIN: begin
                state_d = r_out;
                rstep_d = rstep + 4'd1;
                round_d = rstep == 4'(RSTEPS - 1) ? round + 4'd1 : round;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_reg   <= '0;
            round       <= '0;
            rstep       <= '0;
            bus.data_o  <= '0;
            bus.done_o  <= 1'b0;
            bus.busy_o  <= 1'b0;
        end else begin
            state_reg   <= state_d;
            round       <= round_d;
            rstep       <= rstep_d;
            bus.data_o  <= state == FIN ? state_reg ^ keys[0] : bus.data_o;
            bus.done_o  <= state == FIN;
            bus.busy_o  <= next_state != IDLE;
        end
endmodule

// File: tb/tb_kuznechik_encoder.sv
// tb_kuznechik_encoder: random and standard-vector checks of the encryptor against a byte-level reference model.
module tb_kuznechik_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] sb_x, sb_y;
    int n_vec = 0;
    int n_bad = 0;
    kuznechik_encoder_if bus();
    kuznechik_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    s_convertion u_sb (.x(sb_x), .y(sb_y));
    always #5 clk = ~clk;

    localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [1279:0] KEYS = {
        128'h8899aabbccddeeff0011223344556677, 128'hfedcba98765432100123456789abcdef,
        128'hdb31485315694343228d6aef8cc78c44, 128'h3d4553d8e9cfec6815ebadc40a9ffd04,
        128'h57646468c44a5e28d3e59246f429f1ac, 128'hbd079435165c6432b532e82834da581b,
        128'h51e640757e8745de705727265a0098b1, 128'h5a7925017b9fdd3ed72a91a22286f984,
        128'hbb44e25378c73123a5f32f73cdb6e517, 128'h72e9dd7416bcf45b755dbaa88e4a4043};
    localparam int COEF_HI [16] = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};
    localparam logic [7:0] PI [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // polynomial product then reduction by x^8+x^7+x^6+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
        for (int k = 14; k >= 8; k--) if (p[k]) p ^= 15'h1C3 << (k - 8);
        return p[7:0];
    endfunction
    function automatic logic [127:0] r_step(input logic [127:0] a);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) acc ^= gmul(a[8*i +: 8], 8'(COEF_HI[15 - i]));
        return {acc, a[127:8]};
    endfunction
    function automatic logic [127:0] l_lin(input logic [127:0] a);
        logic [127:0] v;
        v = a;
        for (int i = 0; i < 16; i++) v = r_step(v);
        return v;
    endfunction
    function automatic logic [127:0] s_sub(input logic [127:0] a);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = PI[a[8*i +: 8]];
        return v;
    endfunction
    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [1279:0] k);
        logic [127:0] a;
        a = pt;
        for (int r = 0; r < 9; r++) a = l_lin(s_sub(a ^ k[1279 - 128*r -: 128]));
        return a ^ k[127:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic start_block(input logic [127:0] pt, input logic [1279:0] k);
        bus.start_i = 1'b1;
        bus.data_i = pt;
        bus.round_keys_i = k;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
    endtask
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!bus.done_o && n < 400);
    endtask

    initial begin
        int n, ndone, lat;
        int distinct;
        logic [127:0] ct, rpt;
        logic [1279:0] rk;
        bit seen [256];
        bus.start_i = 1'b0;
        bus.data_i = '0;
        bus.round_keys_i = '0;
        distinct = 0;
        for (int i = 0; i < 256; i++) begin
            sb_x = 8'(i);
            #1 check("pi", 128'(sb_y), 128'(PI[i]));
            if (!seen[sb_y]) distinct++;
            seen[sb_y] = 1'b1;
        end
        check("pi_bijection", 128'(distinct), 128'd256);
        sb_x = 8'h00;
        #1 check("pi_00", 128'(sb_y), 128'hFC);
        sb_x = 8'hFF;
        #1 check("pi_ff", 128'(sb_y), 128'hB6);
        check("model_r", r_step(128'h00000000000000000000000000000100), 128'h94000000000000000000000000000001);
        check("model_l", l_lin(128'h64a59400000000000000000000000000), 128'hd456584dd0e3e84cc3166e4b7fa2890d);
        check("model_std", ref_enc(PT, KEYS), CT);
        repeat (3) @(posedge clk);
        #1 check("rst_data", bus.data_o, '0);
        check("rst_done", 128'(bus.done_o), '0);
        check("rst_busy", 128'(bus.busy_o), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 start_block(PT, KEYS);
        check("busy_after_e0", 128'(bus.busy_o), 128'd1);
        wait_done(n);
        check("std_ct", bus.data_o, CT);
        check("std_latency", 128'(n), 128'd154);
        @(posedge clk);
        #1 check("done_pulse", 128'(bus.done_o), '0);
        check("busy_idle", 128'(bus.busy_o), '0);
        check("data_held", bus.data_o, CT);
        // second start at E50 must be dropped
        start_block(PT, KEYS);
        repeat (49) begin
            @(posedge clk);
            #1;
        end
        start_block(~PT, KEYS);
        bus.data_i = PT;
        ndone = 0;
        lat = 0;
        ct = '0;
        for (int c = 51; c <= 200; c++) begin
            @(posedge clk);
            #1 if (bus.done_o) begin
                ndone++;
                if (ndone == 1) begin
                    lat = c;
                    ct = bus.data_o;
                end
            end
        end
        check("busy_start_ndone", 128'(ndone), 128'd1);
        check("busy_start_lat", 128'(lat), 128'd154);
        check("busy_start_ct", ct, CT);
        // back-to-back: restart inside the done cycle
        start_block(PT, KEYS);
        wait_done(n);
        start_block(PT, KEYS);
        wait_done(n);
        check("b2b_gap", 128'(n + 1), 128'd155);
        check("b2b_ct", bus.data_o, CT);
        // reset in the middle of a block
        start_block(PT, KEYS);
        repeat (80) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1 check("midrst_data", bus.data_o, '0);
        check("midrst_busy", 128'(bus.busy_o), '0);
        check("midrst_done", 128'(bus.done_o), '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        ndone = 0;
        repeat (200) begin
            @(posedge clk);
            #1 if (bus.done_o) ndone++;
        end
        check("midrst_no_done", 128'(ndone), '0);
        start_block(PT, KEYS);
        wait_done(n);
        check("postrst_ct", bus.data_o, CT);
        check("postrst_lat", 128'(n), 128'd154);
        for (int t = 0; t < 4; t++) begin
            rpt = {$urandom, $urandom, $urandom, $urandom};
            for (int w = 0; w < 40; w++) rk[32*w +: 32] = $urandom;
            start_block(rpt, rk);
            wait_done(n);
            check("rand_ct", bus.data_o, ref_enc(rpt, rk));
            check("rand_lat", 128'(n), 128'd154);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
